// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator between the M-stage datapath and a
// word-organised data memory. One request in flight at a time. Sub-word
// stores are performed as read-modify-write of the containing word; sub-word
// loads are extracted from the read word and sign- or zero-extended.
// Misaligned or out-of-range requests get an error response with no memory
// cycle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; classify and latch it on req_valid
// READ    | drive word address, capture mem_rdata into rbuf
// WRITE   | one-cycle word write (SW data or merged SH/SB word)
// RESP    | one-cycle good response, load data on resp_rdata
// ERR     | one-cycle error response, no memory access was made

module mem_access_ctrl #(
    parameter logic [31:0] MEM_BYTES = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [31:0] r_rbuf;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_req_err;
    logic        w_lat_is_load;
    logic [31:0] w_word_addr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    // A request is taken only while idle; synchronous reset has priority in
    // the register blocks, so a request coinciding with reset is ignored.
    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // Classify the incoming request: alignment by access size, unsigned range check.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         w_misaligned = |req_addr[1:0];
            OP_LH, OP_LHU, OP_SH: w_misaligned = req_addr[0];
            default:              w_misaligned = 1'b0;
        endcase
    end

    assign w_out_of_range = (req_addr >= MEM_BYTES);
    assign w_req_err      = w_misaligned || w_out_of_range;

    assign w_lat_is_load  = (r_op <= OP_LBU);
    assign w_word_addr    = {r_addr[31:2], 2'b00};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_nxt = ST_ERR;
                    end else if (req_op == OP_SW) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_READ:  w_state_nxt = w_lat_is_load ? ST_RESP : ST_WRITE;
            ST_WRITE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            ST_ERR:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch on accept, read buffer capture during READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_pc    <= 32'h0;
            r_rbuf  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_pc    <= req_pc;
            end
            if (r_state == ST_READ) begin
                r_rbuf <= mem_rdata;
            end
        end
    end

    // Select the addressed byte and halfword out of the read buffer.
    always_comb begin
        w_byte = r_rbuf[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = r_rbuf[7:0];
            2'd1: w_byte = r_rbuf[15:8];
            2'd2: w_byte = r_rbuf[23:16];
            2'd3: w_byte = r_rbuf[31:24];
            default: w_byte = r_rbuf[7:0];
        endcase
        w_half = r_addr[1] ? r_rbuf[31:16] : r_rbuf[15:0];
    end

    // Load result formatting; stores respond with zero.
    always_comb begin
        w_load_data = 32'h0;
        case (r_op)
            OP_LW:   w_load_data = r_rbuf;
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'h0, w_half};
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'h0, w_byte};
            default: w_load_data = 32'h0;
        endcase
    end

    // Store word: full word for SW, read-modify-write merge for SH/SB.
    always_comb begin
        w_merge = r_rbuf;
        case (r_op)
            OP_SW: w_merge = r_wdata;
            OP_SH: begin
                if (r_addr[1]) begin
                    w_merge[31:16] = r_wdata[15:0];
                end else begin
                    w_merge[15:0] = r_wdata[15:0];
                end
            end
            OP_SB: begin
                case (r_addr[1:0])
                    2'd0: w_merge[7:0]   = r_wdata[7:0];
                    2'd1: w_merge[15:8]  = r_wdata[7:0];
                    2'd2: w_merge[23:16] = r_wdata[7:0];
                    2'd3: w_merge[31:24] = r_wdata[7:0];
                    default: w_merge = r_rbuf;
                endcase
            end
            default: w_merge = r_rbuf;
        endcase
    end

    // FSM outputs decoded from state; the write strobe is masked by reset so
    // a reset landing on the WRITE cycle cannot corrupt memory.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_we     = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_READ: mem_addr = w_word_addr;
            ST_WRITE: begin
                mem_addr  = w_word_addr;
                mem_wdata = w_merge;
                mem_we    = !reset;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = w_load_data;
            end
            ST_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign mem_pc = r_pc;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed vector table, back-to-back held
// requests, reset corner cases, and random traffic against a byte-level
// reference memory.

module tb_mem_access_ctrl;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_BYTES(32'h0000_1000)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_pc     (mem_pc),
        .mem_rdata  (mem_rdata)
    );

    // Word memory the DUT talks to; preloaded through pl_* during reset.
    logic [31:0] env_mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk) begin
        if (pl_we) env_mem[pl_idx] <= pl_data;
        else if (mem_we) env_mem[mem_addr[11:2]] <= mem_wdata;
    end
    assign mem_rdata = env_mem[mem_addr[11:2]];

    // Reference model: flat byte-addressed memory.
    logic [7:0] ref_mem [0:4095];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    function automatic int op_size(input logic [2:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction

    // Compute the expected outcome of one access and apply it to ref_mem.
    task automatic ref_access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                              output logic err, output logic [31:0] rd, output int lat,
                              output int nwr, output logic [31:0] wword);
        int sz;
        logic [31:0] v;
        sz = op_size(op);
        err = ((a % 32'(sz)) != 0) || (a >= 32'd4096);
        rd = 32'h0; nwr = 0; wword = 32'h0; lat = 1;
        if (!err) begin
            if (op <= OP_LBU) begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
                if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
                if (op == OP_LB && v[7])  v = v | 32'hFFFF_FF00;
                rd = v;
                lat = 2;
            end else begin
                for (int i = 0; i < sz; i++) ref_mem[a+i] = wd[8*i +: 8];
                nwr = 1;
                wword = ref_word(int'(a & 32'hFFFF_FFFC));
                lat = (op == OP_SW) ? 2 : 3;
            end
        end
    endtask

    // Issue one request from IDLE and watch it until its response.
    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] pc, input string tag,
                          output logic got_err, output logic [31:0] got_rd, output int lat,
                          output int nwr, output logic [31:0] wdata_seen,
                          output logic [31:0] waddr_seen, output logic [31:0] pc_seen);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_pc = pc;
        @(negedge clk);
        req_valid = 1'b0;
        pc_seen = mem_pc;
        lat = 0; nwr = 0; got_err = 1'b0; got_rd = 32'h0; wdata_seen = 32'h0; waddr_seen = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin
                nwr++;
                wdata_seen = mem_wdata;
                waddr_seen = mem_addr;
            end
            if (resp_valid) begin
                lat = c;
                got_err = resp_err;
                got_rd = resp_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
        logic [31:0] wword;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g_err, r_err;
        logic [31:0] g_rd, g_wd, g_wa, g_pc, r_rd, r_ww, pc, a, wd, w;
        int          g_lat, g_nwr, r_lat, r_nwr, bad, sz;
        logic [2:0]  op;
        logic [2:0]  h_op [6];
        logic [31:0] h_addr [6];
        logic [31:0] exp_rd_q [$];
        int          exp_cyc_q [$];
        int          n_acc, n_resp, last_acc, exp_gap;
        bit          adv;
        int          r;

        vecs[0]  = '{OP_LB,  32'h11,        32'h0,        1'b0, 32'hFFFF_FFAA, 2, 0, 32'h0};
        vecs[1]  = '{OP_LBU, 32'h11,        32'h0,        1'b0, 32'h0000_00AA, 2, 0, 32'h0};
        vecs[2]  = '{OP_LH,  32'h12,        32'h0,        1'b0, 32'hFFFF_8899, 2, 0, 32'h0};
        vecs[3]  = '{OP_LHU, 32'h12,        32'h0,        1'b0, 32'h0000_8899, 2, 0, 32'h0};
        vecs[4]  = '{OP_SW,  32'h20,        32'h1234_5678, 1'b0, 32'h0,        2, 1, 32'h1234_5678};
        vecs[5]  = '{OP_LW,  32'h20,        32'h0,        1'b0, 32'h1234_5678, 2, 0, 32'h0};
        vecs[6]  = '{OP_SB,  32'h32,        32'h0000_00EE, 1'b0, 32'h0,        3, 1, 32'hAAEE_CCDD};
        vecs[7]  = '{OP_SH,  32'h30,        32'h0000_1122, 1'b0, 32'h0,        3, 1, 32'hAAEE_1122};
        vecs[8]  = '{OP_LW,  32'h30,        32'h0,        1'b0, 32'hAAEE_1122, 2, 0, 32'h0};
        vecs[9]  = '{OP_LW,  32'h22,        32'h0,        1'b1, 32'h0,        1, 0, 32'h0};
        vecs[10] = '{OP_SH,  32'h41,        32'hFFFF,     1'b1, 32'h0,        1, 0, 32'h0};
        vecs[11] = '{OP_LW,  32'h1000,      32'h0,        1'b1, 32'h0,        1, 0, 32'h0};
        vecs[12] = '{OP_LW,  32'hFFC,       32'h0,        1'b0, 32'hCAFE_F00D, 2, 0, 32'h0};
        vecs[13] = '{OP_LW,  32'hFFFF_FFFC, 32'h0,        1'b1, 32'h0,        1, 0, 32'h0};
        vecs[14] = '{OP_LH,  32'h13,        32'h0,        1'b1, 32'h0,        1, 0, 32'h0};
        vecs[15] = '{OP_LB,  32'h13,        32'h0,        1'b0, 32'hFFFF_FF88, 2, 0, 32'h0};
        vecs[16] = '{OP_LH,  32'h10,        32'h0,        1'b0, 32'hFFFF_AABB, 2, 0, 32'h0};

        reset = 1'b1; req_valid = 1'b0; req_op = 3'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_pc = 32'h0;

        // Preload both memories identically while reset is held.
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (i == 32'h10 / 4) w = 32'h8899_AABB;
            if (i == 32'h30 / 4) w = 32'hAABB_CCDD;
            if (i == 32'h60 / 4) w = 32'h5A5A_1234;
            if (i == 1023)       w = 32'hCAFE_F00D;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
            @(negedge clk);
            pl_we = 1'b1; pl_idx = 10'(i); pl_data = w;
        end
        @(negedge clk);
        pl_we = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_ready",  32'(req_ready),  32'd1);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_rerr",   32'(resp_err),   32'd0);
        chk("rst_rdata",  resp_rdata,      32'h0);
        chk("rst_maddr",  mem_addr,        32'h0);
        chk("rst_mwdata", mem_wdata,       32'h0);
        chk("rst_mwe",    32'(mem_we),     32'd0);
        chk("rst_mpc",    mem_pc,          32'h0);

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            pc = $urandom;
            ref_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, r_err, r_rd, r_lat, r_nwr, r_ww);
            do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, pc, $sformatf("v%0d", i),
                   g_err, g_rd, g_lat, g_nwr, g_wd, g_wa, g_pc);
            chk($sformatf("v%0d_err", i),   32'(g_err), 32'(vecs[i].err));
            chk($sformatf("v%0d_rdata", i), g_rd,       vecs[i].rdata);
            chk($sformatf("v%0d_lat", i),   g_lat,      vecs[i].lat);
            chk($sformatf("v%0d_nwr", i),   g_nwr,      vecs[i].nwr);
            chk($sformatf("v%0d_pc", i),    g_pc,       pc);
            if (vecs[i].nwr != 0) begin
                chk($sformatf("v%0d_wword", i), g_wd, vecs[i].wword);
                chk($sformatf("v%0d_waddr", i), g_wa, {vecs[i].addr[31:2], 2'b00});
            end
        end

        // req_valid held high through alternating LW/SB requests.
        h_op   = '{OP_LW, OP_SB, OP_LW, OP_SB, OP_LW, OP_SB};
        h_addr = '{32'h50, 32'h51, 32'h50, 32'h53, 32'h50, 32'h50};
        n_acc = 0; n_resp = 0; last_acc = 0; exp_gap = 0; adv = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = h_op[0]; req_addr = h_addr[0]; req_wdata = $urandom;
        req_pc = 32'h100;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (resp_valid) begin
                n_resp++;
                if (exp_rd_q.size() > 0) begin
                    chk($sformatf("hold_r%0d_rdata", n_resp), resp_rdata, exp_rd_q.pop_front());
                    chk($sformatf("hold_r%0d_cyc", n_resp), cyc, exp_cyc_q.pop_front());
                    chk($sformatf("hold_r%0d_err", n_resp), 32'(resp_err), 32'd0);
                end else begin
                    chk("hold_spurious_resp", 32'd1, 32'd0);
                end
            end
            if (req_valid && req_ready) begin
                if (n_acc > 0) chk($sformatf("hold_gap%0d", n_acc), cyc - last_acc, exp_gap);
                ref_access(req_op, req_addr, req_wdata, r_err, r_rd, r_lat, r_nwr, r_ww);
                exp_rd_q.push_back(r_rd);
                exp_cyc_q.push_back(cyc + r_lat);
                exp_gap = r_lat + 1;
                last_acc = cyc;
                n_acc++;
                adv = 1;
            end
            if (n_resp == 6) break;
            @(negedge clk);
            if (adv) begin
                adv = 0;
                if (n_acc < 6) begin
                    req_op = h_op[n_acc]; req_addr = h_addr[n_acc]; req_wdata = $urandom;
                    req_pc = 32'h100 + 32'(4 * n_acc);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("hold_accepts", n_acc, 6);
        chk("hold_resps", n_resp, 6);
        chk("hold_word", env_mem[32'h50 / 4], ref_word(32'h50));

        // Reset landing on the WRITE cycle of an SB.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h61; req_wdata = 32'h77; req_pc = 32'hABC0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_pre_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw_we_gated", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstw_ready",  32'(req_ready),  32'd1);
        chk("rstw_rvalid", 32'(resp_valid), 32'd0);
        chk("rstw_rerr",   32'(resp_err),   32'd0);
        chk("rstw_rdata",  resp_rdata,      32'h0);
        chk("rstw_maddr",  mem_addr,        32'h0);
        chk("rstw_mwdata", mem_wdata,       32'h0);
        chk("rstw_mwe",    32'(mem_we),     32'd0);
        chk("rstw_mpc",    mem_pc,          32'h0);
        chk("rstw_word",   env_mem[32'h60 / 4], 32'h5A5A_1234);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid) bad++;
        end
        chk("rstw_no_resp", bad, 0);

        // Reset coinciding with req_valid: request must not be taken.
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h10; req_pc = 32'h7777;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        chk("rstv_ready", 32'(req_ready), 32'd1);
        chk("rstv_mpc",   mem_pc,         32'h0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid || !req_ready) bad++;
        end
        chk("rstv_no_resp", bad, 0);

        // Random traffic against the byte-level reference.
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            sz = op_size(op);
            r  = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else if (r == 1) a = 32'd4088 + 32'($urandom_range(0, 15));
            else begin
                a = 32'($urandom_range(0, 127));
                if (r < 7) a = a & ~(32'(sz) - 32'd1);
            end
            wd = $urandom;
            pc = $urandom;
            ref_access(op, a, wd, r_err, r_rd, r_lat, r_nwr, r_ww);
            do_req(op, a, wd, pc, $sformatf("rnd%0d", n), g_err, g_rd, g_lat, g_nwr, g_wd, g_wa, g_pc);
            chk($sformatf("rnd%0d_err", n),   32'(g_err), 32'(r_err));
            chk($sformatf("rnd%0d_rdata", n), g_rd,       r_rd);
            chk($sformatf("rnd%0d_lat", n),   g_lat,      r_lat);
            chk($sformatf("rnd%0d_nwr", n),   g_nwr,      r_nwr);
            chk($sformatf("rnd%0d_pc", n),    g_pc,       pc);
            if (r_nwr != 0) begin
                chk($sformatf("rnd%0d_wword", n), g_wd, r_ww);
                chk($sformatf("rnd%0d_waddr", n), g_wa, {a[31:2], 2'b00});
            end
        end

        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (env_mem[i] !== ref_word(4*i)) bad++;
        end
        chk("mem_image_diffs", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the word-organised data memory port; sits between the M-stage load/store datapath and the data memory.
- Accepts one load/store request at a time over a valid/ready handshake and drives word-aligned memory cycles.
- Sub-word stores are done as read-modify-write; sub-word loads are extracted and extended.
- Returns a one-cycle response carrying load data or an error flag for misaligned or out-of-range accesses.

Parameters:
- MEM_BYTES, 32'h0000_1000, byte size of the data memory (1024 words); any address >= MEM_BYTES is an error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- req_addr  in  32  byte address
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0]
- req_pc  in  32  PC of the issuing instruction
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  qualifies resp_valid: access was rejected
- resp_rdata  out  32  load result; 0 for stores and errors
- mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_we  out  1  word write enable, sampled by memory at posedge
- mem_pc  out  32  latched req_pc, for the memory's write trace
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- Byte order is little-endian: byte k of a word is bits [8k+7:8k]; halfword h is bits [16h+15:16h].
- FSM states: IDLE, READ, WRITE, RESP, ERR.
- Reset values:
  - state IDLE.
  - All latched op/addr/wdata/pc/rbuf registers 0.
  - resp_valid, resp_err and mem_we 0; resp_rdata, mem_addr, mem_wdata and mem_pc 0.
- IDLE:
  - req_ready=1.
  - On req_valid at posedge, latch op, addr, wdata and pc, then classify:
    - misaligned (LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0) or addr >= MEM_BYTES -> ERR.
    - loads, SH, SB -> READ.
    - SW -> WRITE.
- READ:
  - mem_addr is driven from the latched address.
  - mem_rdata is captured into rbuf at posedge.
  - Next state: loads -> RESP; SH/SB -> WRITE.
- WRITE:
  - mem_we=1 for exactly this one cycle.
  - mem_wdata:
    - SW: wdata.
    - SH: rbuf with halfword addr[1] replaced by wdata[15:0].
    - SB: rbuf with byte addr[1:0] replaced by wdata[7:0].
  - Next state: RESP.
- RESP:
  - resp_valid=1 and resp_err=0.
  - resp_rdata:
    - LW: rbuf.
    - LH/LB: sign-extended selected half/byte.
    - LHU/LBU: zero-extended.
    - stores: 0.
  - Next state: IDLE.
- ERR:
  - resp_valid=1, resp_err=1, resp_rdata=0.
  - No memory cycle is issued; mem_we stays 0.
  - Next state: IDLE.
- Outside READ/WRITE, mem_addr=0 and mem_we=0. mem_pc always equals the latched pc.
- req_ready=0 in every state except IDLE. A req_valid held high during a busy cycle is neither accepted nor lost; the requester must hold it.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles.
  - SW: 2 cycles.
  - SH/SB: 3 cycles.
  - error: 1 cycle.
- Back-to-back requests: a new request may be accepted in the IDLE cycle immediately after RESP/ERR. Minimum issue interval is 3 cycles for loads and SW, 4 for SH/SB.
- Reset mid-operation:
  - mem_we is gated by !reset, so reset asserted during WRITE produces no memory write.
  - The in-flight request is dropped with no response.
  - State returns to IDLE at that edge.
- Reset asserted in the same cycle as req_valid: the request is not accepted.
- Boundary addresses:
  - addr = MEM_BYTES-4 with LW is legal.
  - addr = MEM_BYTES with LW -> ERR.
  - addr = 32'hFFFF_FFFC -> ERR (the range check is an unsigned compare).

Test Plan:
- Memory word 0x10 preloaded with 0x8899AABB. LB addr 0x11 -> resp_rdata 0xFFFFFFAA, 2 cycles after accept. LBU addr 0x11 -> 0x000000AA. LH addr 0x12 -> 0xFFFF8899. LHU addr 0x12 -> 0x00008899.
- SW addr 0x20, wdata 0x12345678 -> a single mem_we pulse with mem_addr 0x20 and mem_wdata 0x12345678. A following LW 0x20 returns 0x12345678.
- Word 0x30 = 0xAABBCCDD:
  - SB addr 0x32, wdata 0x000000EE -> mem_wdata 0xAAEECCDD, resp 3 cycles after accept.
  - Then SH addr 0x30, wdata 0x00001122 -> word becomes 0xAAEE1122.
- LW addr 0x22 -> resp_err=1 in the next cycle, no mem_we. SH addr 0x41 -> err. LW addr 0x1000 -> err. LW addr 0xFFC -> legal.
- Hold req_valid high continuously with alternating LW/SB -> accepts occur only in IDLE cycles, and every request gets exactly one resp_valid pulse.
- SB in flight, reset asserted in the WRITE cycle -> mem_we stays 0, the target word is unchanged, and no response is issued. The next cycle req_ready=1 and all outputs are 0.
